// File: rtl/shift_pkg.sv
// Shared op encoding, instruction field constants and a bit-reverse helper for the shift unit.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_op_e;

    localparam logic [2:0] FUNCT3_SL   = 3'b001;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    function automatic logic [31:0] bit_rev(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational 32-bit log barrel shifter (16/8/4/2/1); zero latency, no handshake.
module shift_core
    import shift_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [4:0]  shamt,
    input  logic [31:0] data,
    output logic [31:0] result
);

    logic        fill;
    logic [31:0] st0, st1, st2, st3, st4, st5;

    // Left shifts reuse the right-shift datapath by reversing bits on both sides.
    always_comb begin
        fill   = (op == SH_SRA) & data[31];
        st0    = (op == SH_SLL) ? bit_rev(data) : data;
        st1    = shamt[4] ? {{16{fill}}, st0[31:16]} : st0;
        st2    = shamt[3] ? {{8{fill}},  st1[31:8]}  : st1;
        st3    = shamt[2] ? {{4{fill}},  st2[31:4]}  : st2;
        st4    = shamt[1] ? {{2{fill}},  st3[31:2]}  : st3;
        st5    = shamt[0] ? {fill,       st4[31:1]}  : st4;
        result = (op == SH_SLL) ? bit_rev(st5) : st5;
    end

endmodule

// File: rtl/shift_exec.sv
// Two-stage RISC-V shift execute unit (decode -> shift); SHIFT_CHECK_EN enables illegal-encoding flagging.
// Latency 2 cycles; in_ready = stage 1 can advance, everything holds when both stages full and out_ready low.
module shift_exec
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        is_imm,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  shamt_imm,
    input  logic [4:0]  rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  out_rd,
    output logic        out_err
);

    logic        s1_valid_q;
    logic [1:0]  s1_op_q, s1_op_d;
    logic [31:0] s1_operand_q;
    logic [4:0]  s1_shamt_q, s1_shamt_d;
    logic [4:0]  s1_rd_q;
    logic        s1_err_q, s1_err_d;

    logic        s2_valid_q;
    logic [31:0] s2_result_q, s2_result_d;
    logic [4:0]  s2_rd_q;
    logic        s2_err_q;

    logic        s1_adv, s2_adv;
    logic [31:0] core_res;
    logic        unused_rs2_hi;

    assign unused_rs2_hi = ^rs2_val[31:5];

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = rst_n & s1_adv;

`ifdef SHIFT_CHECK_EN
    always_comb begin
        s1_shamt_d = is_imm ? shamt_imm : rs2_val[4:0];
        s1_op_d    = SH_SLL;
        s1_err_d   = 1'b1;
        if (funct3 == FUNCT3_SL && funct7 == FUNCT7_BASE) begin
            s1_op_d  = SH_SLL;
            s1_err_d = 1'b0;
        end else if (funct3 == FUNCT3_SR && funct7 == FUNCT7_BASE) begin
            s1_op_d  = SH_SRL;
            s1_err_d = 1'b0;
        end else if (funct3 == FUNCT3_SR && funct7 == FUNCT7_ALT) begin
            s1_op_d  = SH_SRA;
            s1_err_d = 1'b0;
        end
    end
`else
    logic unused_fields;
    assign unused_fields = ^{funct3[1:0], funct7[6], funct7[4:0]};

    always_comb begin
        s1_shamt_d = is_imm ? shamt_imm : rs2_val[4:0];
        s1_err_d   = 1'b0;
        if (!funct3[2]) begin
            s1_op_d = SH_SLL;
        end else if (funct7[5]) begin
            s1_op_d = SH_SRA;
        end else begin
            s1_op_d = SH_SRL;
        end
    end
`endif

    shift_core u_core (
        .op     (s1_op_q),
        .shamt  (s1_shamt_q),
        .data   (s1_operand_q),
        .result (core_res)
    );

    // Illegal requests still flow through but carry a zero result.
    assign s2_result_d = s1_err_q ? 32'h0 : core_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= SH_SLL;
            s1_operand_q <= '0;
            s1_shamt_q   <= '0;
            s1_rd_q      <= '0;
            s1_err_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_rd_q      <= '0;
            s2_err_q     <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_q <= s2_result_d;
                    s2_rd_q     <= s1_rd_q;
                    s2_err_q    <= s1_err_q;
                end
            end
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_op_q      <= s1_op_d;
                    s1_operand_q <= rs1_val;
                    s1_shamt_q   <= s1_shamt_d;
                    s1_rd_q      <= rd;
                    s1_err_q     <= s1_err_d;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_result_q;
    assign out_rd    = s2_rd_q;
    assign out_err   = s2_err_q;

endmodule

// File: tb/tb_shift_exec.sv
// Scoreboard bench for shift_exec: directed requests push expectations, a monitor pops on each output transfer.
module tb_shift_exec;

`ifdef SHIFT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_imm;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  shamt_imm, rd;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic [4:0]  out_rd;
    logic        out_err;

    shift_exec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .funct7    (funct7),
        .is_imm    (is_imm),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .shamt_imm (shamt_imm),
        .rd        (rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_rd    (out_rd),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: scoreboard pop on transfer, plus output stability while stalled.
    logic        hold_p = 1'b0;
    logic [37:0] hold_v;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_p = 1'b0;
        end else begin
            if (hold_p) begin
                check("hold_valid", {63'b0, out_valid}, 64'd1);
                check("hold_data", {26'b0, result, out_rd, out_err}, {26'b0, hold_v});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: rd=%0d result=%0h with empty scoreboard", out_rd, result);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_rd", {59'b0, out_rd}, {59'b0, mon_e.rd});
                    check("result", {32'b0, result}, {32'b0, mon_e.res});
                    check("out_err", {63'b0, out_err}, {63'b0, mon_e.err});
                    pop_cyc.push_back(cyc);
                end
            end
            hold_p = out_valid && !out_ready;
            hold_v = {result, out_rd, out_err};
        end
    end

    // Call at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic send(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] sh,
                        input logic [4:0] rdv, input logic [31:0] exp_res, input logic exp_err);
        int   t;
        bit   done;
        exp_t e;
        t = 0;
        done = 0;
        funct3 = f3; funct7 = f7; is_imm = imm;
        rs1_val = r1; rs2_val = r2; shamt_imm = sh; rd = rdv;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.rd = rdv; e.res = exp_res; e.err = exp_err;
                exp_q.push_back(e);
                done = 1;
            end else if (++t > 50) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: rd=%0d never accepted", rdv);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        in_valid = 0; funct3 = 0; funct7 = 0; is_imm = 0;
        rs1_val = 0; rs2_val = 0; shamt_imm = 0; rd = 0; out_ready = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_result", {32'b0, result}, 64'd0);
        check("rst_out_rd", {59'b0, out_rd}, 64'd0);
        check("rst_out_err", {63'b0, out_err}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1; out_ready = 1;
        @(posedge clk); #1;

        // First request with an empty pipeline also pins down the 2-cycle latency.
        send(3'b101, 7'h20, 0, 32'h8000_0000, 32'h0000_001F, 5'd0, 5'd5, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        check("lat_edge_n", {63'b0, out_valid}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_edge_n1", {63'b0, out_valid}, 64'd1);
        @(posedge clk); #1;

        send(3'b101, 7'h00, 1, 32'hF000_000F, 32'h0, 5'd4,  5'd6,  32'h0F00_0000, 0);
        send(3'b101, 7'h20, 1, 32'hF000_000F, 32'h0, 5'd4,  5'd7,  32'hFF00_0000, 0);
        send(3'b001, 7'h00, 0, 32'h0000_0001, 32'hFFFF_FFE1, 5'd0, 5'd8, 32'h0000_0002, 0);
        send(3'b001, 7'h00, 0, 32'h0000_0001, 32'h0, 5'd0,  5'd9,  32'h0000_0001, 0);
        send(3'b001, 7'h00, 1, 32'h0000_0003, 32'h0, 5'd31, 5'd10, 32'h8000_0000, 0);
        send(3'b101, 7'h00, 0, 32'h8000_0000, 32'h3F, 5'd0, 5'd11, 32'h0000_0001, 0);
        send(3'b101, 7'h20, 1, 32'h7FFF_FFFF, 32'h0, 5'd4,  5'd12, 32'h07FF_FFFF, 0);
        send(3'b101, 7'h20, 1, 32'h8000_0000, 32'h0, 5'd0,  5'd13, 32'h8000_0000, 0);
        // Encodings that are illegal when checking, decoded by funct3[2]/funct7[5] otherwise.
        send(3'b101, 7'h01, 1, 32'hF000_0000, 32'h0, 5'd4, 5'd14, CHK ? 32'h0 : 32'h0F00_0000, CHK);
        send(3'b000, 7'h00, 1, 32'h0000_0001, 32'h0, 5'd3, 5'd15, CHK ? 32'h0 : 32'h0000_0008, CHK);
        send(3'b001, 7'h20, 1, 32'h0000_0001, 32'h0, 5'd4, 5'd16, CHK ? 32'h0 : 32'h0000_0010, CHK);
        wait_drain();

        // Backpressure: two requests fill the pipe, the third must wait.
        out_ready = 0;
        send(3'b001, 7'h00, 1, 32'h0000_0001, 32'h0, 5'd1, 5'd1, 32'h0000_0002, 0);
        send(3'b101, 7'h00, 1, 32'h0000_0100, 32'h0, 5'd8, 5'd2, 32'h0000_0001, 0);
        funct3 = 3'b101; funct7 = 7'h20; is_imm = 1; rs1_val = 32'hFFFF_FF00; shamt_imm = 5'd4; rd = 5'd3;
        in_valid = 1;
        @(negedge clk);
        check("bp_in_ready_full", {63'b0, in_ready}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1;
        n0 = pop_cyc.size();
        send(3'b101, 7'h20, 1, 32'hFFFF_FF00, 32'h0, 5'd4, 5'd3, 32'hFFFF_FFF0, 0);
        wait_drain();
        check("bp_count", 64'(pop_cyc.size() - n0), 64'd3);
        if (pop_cyc.size() >= n0 + 3)
            check("bp_one_per_cycle", 64'(pop_cyc[n0+2] - pop_cyc[n0]), 64'd2);

        // Reset with both stages occupied.
        out_ready = 0;
        send(3'b001, 7'h00, 1, 32'h0000_00FF, 32'h0, 5'd4, 5'd20, 32'h0000_0FF0, 0);
        send(3'b001, 7'h00, 1, 32'h0000_00FF, 32'h0, 5'd8, 5'd21, 32'h0000_FF00, 0);
        #2;
        rst_n = 0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'b0, in_ready}, 64'd0);
        check("midrst_result", {32'b0, result}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_output", {63'b0, out_valid}, 64'd0);
        end
        @(posedge clk); #1;
        send(3'b101, 7'h00, 0, 32'hDEAD_BEEF, 32'h0000_0010, 5'd0, 5'd22, 32'h0000_DEAD, 0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
